// File: rtl/pet_mem_pkg.sv
// ----------------------------------------------------------------------------
// pet_mem_pkg: shared types and constants for the PET memory controller. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pet_mem_pkg;

   typedef enum logic [2:0] {
      RAM      = 3'd0,
      VRAM     = 3'd1,
      ROM      = 3'd2,
      IO       = 3'd3,
      UNMAPPED = 3'd4
   } region_t;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_GRANT = 2'd1,
      DMA_ACK   = 2'd2,
      DMA_HOLD  = 2'd3
   } dma_state_t;

   localparam logic [15:0] CTRL_ADDR = 16'hFFF0;

   localparam int CTRL_WP_LO     = 0;
   localparam int CTRL_WP_HI     = 1;
   localparam int CTRL_BANK_LO   = 2;
   localparam int CTRL_BANK_HI   = 3;
   localparam int CTRL_VRAM_PEEK = 5;
   localparam int CTRL_IO_PEEK   = 6;
   localparam int CTRL_MAP_EN    = 7;

endpackage

`default_nettype wire

// File: rtl/pet_memdecode.sv
// ----------------------------------------------------------------------------
// pet_memdecode: CPU address + ctrl to region, physical address and protect flag. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pet_memdecode
   import pet_mem_pkg::*;
#(
   parameter int RAM_KB    = 32,
   parameter int EXPANSION = 1,
   parameter int PHYS_W    = 17
) (
   input  logic [15:0]       addr,
   input  logic [7:0]        ctrl,
   output logic [2:0]        region,
   output logic [PHYS_W-1:0] phys,
   output logic              wprot
);

   localparam logic [16:0] RAM_TOP = 17'(RAM_KB * 1024);

   logic map_en;
   logic unused_ctrl;

   assign map_en      = (EXPANSION != 0) && ctrl[CTRL_MAP_EN];
   assign unused_ctrl = ctrl[4];

   always_comb begin
      region = UNMAPPED;
      phys   = PHYS_W'(addr[14:0]);
      wprot  = 1'b0;
      if (!addr[15]) begin
         region = ({1'b0, addr} < RAM_TOP) ? RAM : UNMAPPED;
      end else if (map_en) begin
         // Upper 32 KB banks into the extended RAM unless a peek-through bit keeps VRAM/IO visible
         if (!addr[14]) begin
            if (ctrl[CTRL_VRAM_PEEK] && addr[13:12] == 2'b00) begin
               region = VRAM;
            end else begin
               region = RAM;
               phys   = PHYS_W'({1'b1, ctrl[CTRL_BANK_LO], addr[14:0]});
               wprot  = ctrl[CTRL_WP_LO];
            end
         end else begin
            if (ctrl[CTRL_IO_PEEK] && addr[13:11] == 3'b101) begin
               region = IO;
            end else begin
               region = RAM;
               phys   = PHYS_W'({1'b1, ctrl[CTRL_BANK_HI], addr[14:0]});
               wprot  = ctrl[CTRL_WP_HI];
            end
         end
      end else begin
         case (addr[14:12])
            3'b000:                 region = VRAM;
            3'b001, 3'b010, 3'b011: region = UNMAPPED;
            3'b110:                 region = addr[11] ? IO : ROM;
            default:                region = ROM;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/pet_memctl.sv
// ----------------------------------------------------------------------------
// pet_memctl: PET memory controller with 8096 expansion and a DMA slot on the RAM port. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pet_memctl
   import pet_mem_pkg::*;
#(
   parameter int         RAM_KB    = 32,
   parameter int         EXPANSION = 1,
   parameter int         PHYS_W    = 17,
   parameter logic [7:0] OPEN_BUS  = 8'h55
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce_1m,
   input  logic [15:0]       addr,
   input  logic [7:0]        data_in,
   input  logic              we,
   output logic [7:0]        data_out,
   output logic [PHYS_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   input  logic [7:0]        mem_q,
   output logic              vram_we,
   output logic              io_we,
   input  logic [7:0]        vram_q,
   input  logic [7:0]        rom_q,
   input  logic [7:0]        io_q,
   input  logic              dma_req,
   input  logic [PHYS_W-1:0] dma_addr,
   input  logic [7:0]        dma_din,
   input  logic              dma_we,
   output logic              dma_ack,
   output logic [7:0]        dma_dout,
   output logic [7:0]        ctrl
);

   logic [2:0]        dec_region;
   logic [PHYS_W-1:0] dec_phys;
   logic              dec_wprot;
   logic              ctrl_hit;
   logic              cpu_wr;
   logic              dma_grant;
   region_t           region_q;
   dma_state_t        state;

   pet_memdecode #(
      .RAM_KB    (RAM_KB),
      .EXPANSION (EXPANSION),
      .PHYS_W    (PHYS_W)
   ) u_decode (
      .addr   (addr),
      .ctrl   (ctrl),
      .region (dec_region),
      .phys   (dec_phys),
      .wprot  (dec_wprot)
   );

   assign ctrl_hit  = (addr == CTRL_ADDR);
   assign cpu_wr    = ce_1m & we & ~ctrl_hit & ~reset;
   // The CPU slot always owns the port, so a stray ce_1m during GRANT silences the DMA strobe
   assign dma_grant = (state == DMA_GRANT) & ~ce_1m;

   assign mem_addr = dma_grant ? dma_addr : dec_phys;
   assign mem_din  = dma_grant ? dma_din  : data_in;
   assign mem_we   = (cpu_wr & (dec_region == RAM) & ~dec_wprot) | (dma_grant & dma_we & ~reset);
   assign vram_we  = cpu_wr & (dec_region == VRAM);
   assign io_we    = cpu_wr & (dec_region == IO);
   assign dma_dout = mem_q;

   generate
      if (EXPANSION != 0) begin : g_ctrl_reg
         always_ff @(posedge clk) begin
            if (reset) begin
               ctrl <= 8'h00;
            end else if (ce_1m && we && ctrl_hit) begin
               ctrl <= data_in;
            end
         end
      end else begin : g_ctrl_tied
         assign ctrl = 8'h00;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         region_q <= UNMAPPED;
      end else if (ce_1m) begin
         region_q <= region_t'(dec_region);
      end
   end

   always_comb begin
      data_out = OPEN_BUS;
      case (region_q)
         RAM:     data_out = mem_q;
         VRAM:    data_out = vram_q;
         ROM:     data_out = rom_q;
         IO:      data_out = io_q;
         default: data_out = OPEN_BUS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= DMA_IDLE;
         dma_ack <= 1'b0;
      end else begin
         dma_ack <= 1'b0;
         case (state)
            DMA_IDLE: begin
               if (dma_req && !ce_1m) state <= DMA_GRANT;
            end
            DMA_GRANT: begin
               if (ce_1m) begin
                  state <= DMA_IDLE;
               end else begin
                  state   <= DMA_ACK;
                  dma_ack <= 1'b1;
               end
            end
            DMA_ACK: begin
               state <= DMA_HOLD;
            end
            DMA_HOLD: begin
               if (!dma_req) state <= DMA_IDLE;
            end
            default: state <= DMA_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pet_memctl.sv
// ----------------------------------------------------------------------------
// tb_pet_memctl: vector table plus read scoreboard for pet_memctl. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pet_memctl;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        w;
      logic [2:0]  stb;    // {mem_we, vram_we, io_we}
      logic        chk_ma;
      logic [16:0] maddr;
      logic [7:0]  rd;
      logic [7:0]  ctl;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, ce_1m, we, dma_req, dma_we;
   logic [15:0] addr;
   logic [7:0]  data_in, dma_din;
   logic [16:0] dma_addr;
   logic [7:0]  data_out, mem_din, dma_dout, ctrl;
   logic [16:0] mem_addr;
   logic        mem_we, vram_we, io_we, dma_ack;
   logic [7:0]  mem_q, vram_q, rom_q, io_q;

   logic [7:0]  d8_data_out, d8_mem_din, d8_dma_dout, d8_ctrl;
   logic [16:0] d8_mem_addr;
   logic        d8_mem_we, d8_vram_we, d8_io_we, d8_dma_ack;

   logic [7:0]  ram  [0:131071];
   logic [7:0]  vram [0:2047];
   logic [7:0]  sb[$];
   logic [7:0]  sb_exp;
   logic        rd_pend = 1'b0;
   int          total = 0, bad = 0, ack_cnt = 0, ack0;
   vec_t        vecs[$];

   pet_memctl #(.RAM_KB(32), .EXPANSION(1), .PHYS_W(17), .OPEN_BUS(8'h55)) dut (
      .clk(clk), .reset(reset), .ce_1m(ce_1m), .addr(addr), .data_in(data_in), .we(we),
      .data_out(data_out), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_q(mem_q),
      .vram_we(vram_we), .io_we(io_we), .vram_q(vram_q), .rom_q(rom_q), .io_q(io_q),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
      .dma_ack(dma_ack), .dma_dout(dma_dout), .ctrl(ctrl));

   pet_memctl #(.RAM_KB(8), .EXPANSION(1), .PHYS_W(17), .OPEN_BUS(8'h55)) dut8 (
      .clk(clk), .reset(reset), .ce_1m(ce_1m), .addr(addr), .data_in(data_in), .we(we),
      .data_out(d8_data_out), .mem_addr(d8_mem_addr), .mem_din(d8_mem_din), .mem_we(d8_mem_we),
      .mem_q(mem_q), .vram_we(d8_vram_we), .io_we(d8_io_we), .vram_q(vram_q), .rom_q(rom_q),
      .io_q(io_q), .dma_req(1'b0), .dma_addr(17'h00000), .dma_din(8'h00), .dma_we(1'b0),
      .dma_ack(d8_dma_ack), .dma_dout(d8_dma_dout), .ctrl(d8_ctrl));

   initial forever #5 clk = ~clk;

   // Synchronous memory models with one clock of read latency
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_q <= ram[mem_addr];
      if (vram_we) vram[addr[10:0]] <= data_in;
      vram_q <= vram[addr[10:0]];
      rom_q  <= addr[7:0] ^ 8'h5A;
      io_q   <= {4'hE, addr[3:0]};
   end

   always @(posedge clk) rd_pend <= ce_1m && !we && !reset;

   always @(negedge clk) begin
      if (dma_ack) ack_cnt++;
      if (rd_pend) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: data_out=%h with no expected read", data_out);
         end else begin
            sb_exp = sb.pop_front();
            chk("data_out", 32'(data_out), 32'(sb_exp));
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      tick;
      addr = v.a; data_in = v.d; we = v.w; ce_1m = 1'b1;
      if (!v.w) sb.push_back(v.rd);
      #3;
      chk("mem_we", 32'(mem_we), 32'(v.stb[2]));
      chk("vram_we", 32'(vram_we), 32'(v.stb[1]));
      chk("io_we", 32'(io_we), 32'(v.stb[0]));
      if (v.chk_ma) chk("mem_addr", 32'(mem_addr), 32'(v.maddr));
      tick;
      ce_1m = 1'b0; we = 1'b0;
      #3;
      chk("ctrl", 32'(ctrl), 32'(v.ctl));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //                 addr      data   w     stb     cma   maddr      rd     ctl
      vecs.push_back(vec_t'{16'h0100, 8'hA5, 1'b1, 3'b100, 1'b1, 17'h00100, 8'h00, 8'h00});
      vecs.push_back(vec_t'{16'h0100, 8'h00, 1'b0, 3'b000, 1'b1, 17'h00100, 8'hA5, 8'h00});
      vecs.push_back(vec_t'{16'h8005, 8'h3C, 1'b1, 3'b010, 1'b0, 17'h00000, 8'h00, 8'h00});
      vecs.push_back(vec_t'{16'h8805, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'h3C, 8'h00});
      vecs.push_back(vec_t'{16'hC010, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'h4A, 8'h00});
      vecs.push_back(vec_t'{16'hE810, 8'h77, 1'b1, 3'b001, 1'b0, 17'h00000, 8'h00, 8'h00});
      vecs.push_back(vec_t'{16'hE812, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'hE2, 8'h00});
      vecs.push_back(vec_t'{16'h9000, 8'h99, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'h00});
      vecs.push_back(vec_t'{16'h9000, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'h55, 8'h00});
      vecs.push_back(vec_t'{16'hC000, 8'h12, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'h00});
      vecs.push_back(vec_t'{16'hC000, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'h5A, 8'h00});
      vecs.push_back(vec_t'{16'hFFF0, 8'h80, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'h80});
      vecs.push_back(vec_t'{16'h9000, 8'h11, 1'b1, 3'b100, 1'b1, 17'h11000, 8'h00, 8'h80});
      vecs.push_back(vec_t'{16'h9000, 8'h00, 1'b0, 3'b000, 1'b1, 17'h11000, 8'h11, 8'h80});
      vecs.push_back(vec_t'{16'hFFF0, 8'h84, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'h84});
      vecs.push_back(vec_t'{16'h9000, 8'h22, 1'b1, 3'b100, 1'b1, 17'h19000, 8'h00, 8'h84});
      vecs.push_back(vec_t'{16'h9000, 8'h00, 1'b0, 3'b000, 1'b1, 17'h19000, 8'h22, 8'h84});
      vecs.push_back(vec_t'{16'hFFF0, 8'hA1, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'hA1});
      vecs.push_back(vec_t'{16'h8100, 8'h5E, 1'b1, 3'b010, 1'b0, 17'h00000, 8'h00, 8'hA1});
      vecs.push_back(vec_t'{16'h8100, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'h5E, 8'hA1});
      vecs.push_back(vec_t'{16'hA000, 8'h66, 1'b1, 3'b000, 1'b1, 17'h12000, 8'h00, 8'hA1});
      vecs.push_back(vec_t'{16'hA000, 8'h00, 1'b0, 3'b000, 1'b1, 17'h12000, 8'h00, 8'hA1});
      vecs.push_back(vec_t'{16'hC000, 8'h33, 1'b1, 3'b100, 1'b1, 17'h14000, 8'h00, 8'hA1});
      vecs.push_back(vec_t'{16'hC000, 8'h00, 1'b0, 3'b000, 1'b1, 17'h14000, 8'h33, 8'hA1});
      vecs.push_back(vec_t'{16'hFFF0, 8'h00, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'h00});
      vecs.push_back(vec_t'{16'hFFF0, 8'h00, 1'b0, 3'b000, 1'b0, 17'h00000, 8'hAA, 8'h00});
      vecs.push_back(vec_t'{16'h0100, 8'h00, 1'b0, 3'b000, 1'b1, 17'h00100, 8'hA5, 8'h00});

      for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
      for (int i = 0; i < 2048; i++) vram[i] = 8'h00;
      reset = 1'b1; ce_1m = 1'b0; we = 1'b0; addr = 16'h0000; data_in = 8'h00;
      dma_req = 1'b0; dma_addr = 17'h00000; dma_din = 8'h00; dma_we = 1'b0;

      // Reset state, with a CPU write attempted while reset is held
      tick; tick;
      ce_1m = 1'b1; we = 1'b1; addr = 16'h0100; data_in = 8'hFF;
      #3;
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'h55);
      chk("rst_ctrl", 32'(ctrl), 32'h00);
      chk("rst_dma_ack", 32'(dma_ack), 32'd0);
      tick;
      ce_1m = 1'b0; we = 1'b0;
      #3;
      chk("rst_data_out_hold", 32'(data_out), 32'h55);
      tick;
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // RAM_KB=8 instance: $3000 is past the top of base RAM
      tick;
      addr = 16'h3000; data_in = 8'hAA; we = 1'b1; ce_1m = 1'b1;
      #3;
      chk("kb8_mem_we", 32'(d8_mem_we), 32'd0);
      chk("kb32_mem_we", 32'(mem_we), 32'd1);
      tick;
      ce_1m = 1'b0; we = 1'b0;
      tick;
      ce_1m = 1'b1; sb.push_back(8'hAA);
      tick;
      ce_1m = 1'b0;
      #3;
      chk("kb8_open_bus", 32'(d8_data_out), 32'h55);

      // DMA read requested during a CPU cycle: grant waits for ce_1m to drop
      tick;
      ce_1m = 1'b1; we = 1'b0; addr = 16'hC010; sb.push_back(8'h4A);
      dma_req = 1'b1; dma_addr = 17'h00100; dma_we = 1'b0;
      ack0 = ack_cnt;
      #3;
      chk("dma_wait_ack", 32'(dma_ack), 32'd0);
      chk("cpu_owns_port", 32'(mem_addr), 32'h04010);
      tick;
      ce_1m = 1'b0;
      #3;
      chk("dma_idle_ack", 32'(dma_ack), 32'd0);
      tick;
      #3;
      chk("dma_grant_addr", 32'(mem_addr), 32'h00100);
      chk("dma_grant_ack", 32'(dma_ack), 32'd0);
      tick;
      #3;
      chk("dma_ack", 32'(dma_ack), 32'd1);
      chk("dma_dout", 32'(dma_dout), 32'hA5);
      tick;
      #3;
      chk("dma_ack_once", 32'(dma_ack), 32'd0);
      tick; tick; tick;
      chk("dma_one_ack", 32'(ack_cnt - ack0), 32'd1);
      dma_req = 1'b0;
      tick; tick;

      // DMA write, then read it back through the CPU path
      dma_req = 1'b1; dma_addr = 17'h00300; dma_din = 8'h7E; dma_we = 1'b1;
      tick;
      #3;
      chk("dmaw_mem_we", 32'(mem_we), 32'd1);
      chk("dmaw_mem_addr", 32'(mem_addr), 32'h00300);
      chk("dmaw_mem_din", 32'(mem_din), 32'h7E);
      tick;
      #3;
      chk("dmaw_ack", 32'(dma_ack), 32'd1);
      tick;
      dma_req = 1'b0; dma_we = 1'b0;
      tick;
      run_vec(vec_t'{16'h0300, 8'h00, 1'b0, 3'b000, 1'b1, 17'h00300, 8'h7E, 8'h00});

      // Reset landing in the GRANT cycle
      run_vec(vec_t'{16'hFFF0, 8'h80, 1'b1, 3'b000, 1'b0, 17'h00000, 8'h00, 8'h80});
      tick;
      dma_req = 1'b1; dma_addr = 17'h00100; dma_din = 8'hEE; dma_we = 1'b1;
      ack0 = ack_cnt;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
      #3;
      chk("rstdma_ctrl", 32'(ctrl), 32'h00);
      chk("rstdma_data_out", 32'(data_out), 32'h55);
      tick; tick; tick; tick;
      chk("rstdma_no_ack", 32'(ack_cnt - ack0), 32'd0);
      dma_req = 1'b1; dma_addr = 17'h00300;
      tick; tick;
      #3;
      chk("rstdma_idle_ack", 32'(dma_ack), 32'd1);
      chk("rstdma_idle_dout", 32'(dma_dout), 32'h7E);
      tick;
      dma_req = 1'b0;
      tick; tick;

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
